// File: rtl/bit_deposit_pkg.sv
// Shared constants and state type for the bit-deposit register.
package bit_deposit_pkg;
  localparam int WORD_W = 16;
  localparam int OP_W = 4;
  localparam logic [WORD_W-1:0] MASK_FULL = 16'hFFFF;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;
endpackage

// File: rtl/bit_deposit_16bit_op_decode_16.sv
// 4-to-16 one-hot decoder of the bit index, gated by the accept strobe.
module op_decode_16
  import bit_deposit_pkg::*;
(
  input  logic            en,
  input  logic [OP_W-1:0] op,
  output logic [WORD_W-1:0] we
);
  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_dec
    assign we[gi] = en && (op == OP_W'(gi));
  end
endmodule

// File: rtl/bit_deposit_16bit.sv
// Bit-addressed 16-bit deposit register with valid/ready word output.
// Optional out_parity port enabled by defining BIT_DEPOSIT_PARITY_EN.
module bit_deposit_16bit
  import bit_deposit_pkg::*;
#(
  parameter bit CLEAR_ON_COMMIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bit,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [WORD_W-1:0] out_mask
`ifdef BIT_DEPOSIT_PARITY_EN
  ,
  output logic              out_parity
`endif
);
  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] mask_q, mask_d;
  logic [WORD_W-1:0] we;
  logic              accept;

  assign accept = in_valid && (state_q == COLLECT);

  op_decode_16 u_dec (
    .en (accept),
    .op (in_op),
    .we (we)
  );

  always_comb begin
    state_d = state_q;
    word_d  = (word_q & ~we) | ({WORD_W{in_bit}} & we);
    mask_d  = mask_q | we;
    case (state_q)
      COLLECT: begin
        if (accept && (in_last || mask_d == MASK_FULL)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = COLLECT;
          mask_d  = '0;
          if (CLEAR_ON_COMMIT) begin
            word_d = '0;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      word_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
    end
  end

  // Handshake flags decode the state register only; no input-to-output path.
  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign out_word  = word_q;
  assign out_mask  = mask_q;

`ifdef BIT_DEPOSIT_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = ^(word_d & mask_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif
endmodule

// File: tb/tb_bit_deposit_16bit.sv
// Directed bench: instance u_dut clears on commit, instance u_keep keeps word bits.
module tb_bit_deposit_16bit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_bit, in_last, out_ready;
  logic [3:0]  in_op;
  logic        in_ready, out_valid, k_in_ready, k_out_valid;
  logic [15:0] out_word, out_mask, k_out_word, k_out_mask;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

`ifdef BIT_DEPOSIT_PARITY_EN
  logic out_parity, k_out_parity;
`endif

  bit_deposit_16bit #(.CLEAR_ON_COMMIT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .in_op(in_op), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_mask(out_mask)
`ifdef BIT_DEPOSIT_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  bit_deposit_16bit #(.CLEAR_ON_COMMIT(1'b0)) u_keep (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(k_in_ready),
    .in_bit(in_bit), .in_op(in_op), .in_last(in_last), .out_valid(k_out_valid),
    .out_ready(out_ready), .out_word(k_out_word), .out_mask(k_out_mask)
`ifdef BIT_DEPOSIT_PARITY_EN
    , .out_parity(k_out_parity)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic write_bit(input logic [3:0] op, input logic b, input logic last);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("write_wait_ready", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1; in_op = op; in_bit = b; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    pat = 16'hA5C3;
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_op = 4'd0;
    in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_word", out_word, 16'h0000);
    check("rst_mask", out_mask, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full word in index order
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("full_valid_before_last", {15'd0, out_valid}, 16'd0);
      write_bit(4'(i), pat[i], 1'b0);
    end
    check("full_valid", {15'd0, out_valid}, 16'd1);
    check("full_in_ready", {15'd0, in_ready}, 16'd0);
    check("full_word", out_word, 16'hA5C3);
    check("full_mask", out_mask, 16'hFFFF);
`ifdef BIT_DEPOSIT_PARITY_EN
    check("full_parity", {15'd0, out_parity}, 16'd0);
`endif
    handshake();
    check("commit_in_ready", {15'd0, in_ready}, 16'd1);
    check("commit_valid", {15'd0, out_valid}, 16'd0);
    check("commit_word_cleared", out_word, 16'h0000);
    check("commit_mask_cleared", out_mask, 16'h0000);
    check("keep_word_retained", k_out_word, 16'hA5C3);
    check("keep_mask_cleared", k_out_mask, 16'h0000);

    // Partial word
    write_bit(4'd3, 1'b1, 1'b0);
    write_bit(4'd12, 1'b1, 1'b1);
    check("partial_valid", {15'd0, out_valid}, 16'd1);
    check("partial_word", out_word, 16'h1008);
    check("partial_mask", out_mask, 16'h1008);
    check("keep_partial_word", k_out_word, 16'hB5CB);

    // Backpressure with in_valid held high
    in_valid = 1'b1; in_op = 4'd0; in_bit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", {15'd0, in_ready}, 16'd0);
      check("bp_word", out_word, 16'h1008);
    end
    in_valid = 1'b0;
    handshake();
    check("bp_after_word", out_word, 16'h0000);
    check("bp_after_mask", out_mask, 16'h0000);

    // Duplicate index
    write_bit(4'd8, 1'b1, 1'b0);
    write_bit(4'd8, 1'b0, 1'b1);
    check("dup_word", out_word, 16'h0000);
    check("dup_mask", out_mask, 16'h0100);
    handshake();

    // Reset mid-collection
    for (int i = 0; i < 7; i++) write_bit(4'(i), 1'b1, 1'b0);
    check("pre_rst_mask", out_mask, 16'h007F);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {15'd0, in_ready}, 16'd1);
    check("midrst_valid", {15'd0, out_valid}, 16'd0);
    check("midrst_word", out_word, 16'h0000);
    check("midrst_mask", out_mask, 16'h0000);
    check("midrst_keep_word", k_out_word, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    write_bit(4'd5, 1'b1, 1'b1);
    check("postrst_word", out_word, 16'h0020);
    check("postrst_mask", out_mask, 16'h0020);
    check("postrst_keep_word", k_out_word, 16'h0020);
    handshake();

    // Word retention when not clearing on commit
    for (int i = 0; i < 8; i++) write_bit(4'(i), 1'b1, (i == 7));
    check("ff_word", k_out_word, 16'h00FF);
    handshake();
    write_bit(4'd15, 1'b1, 1'b1);
    check("keep_final_word", k_out_word, 16'h80FF);
    check("keep_final_mask", k_out_mask, 16'h8000);
    check("keep_final_valid", {15'd0, k_out_valid}, 16'd1);
    check("clear_final_word", out_word, 16'h8000);
`ifdef BIT_DEPOSIT_PARITY_EN
    check("keep_final_parity", {15'd0, k_out_parity}, 16'd1);
`endif
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
